// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters (master side) and the round-robin
// select arbiter (slave side).
interface rr_sel_arbiter_if #(
  parameter int N   = 3,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic           rel;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           timeout;

  modport master (
    output req,
    output rel,
    input  gnt,
    input  gnt_id,
    input  gnt_vld,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output gnt,
    output gnt_id,
    output gnt_vld,
    output timeout
  );
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin owner of a one-hot mux select bus: one registered grant at a time,
// a forced idle cycle between owners, and an optional per-owner hold limit.

module rr_sel_arbiter_chk #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input logic           clk,
  input logic           rst_n,
  input logic [N-1:0]   gnt,
  input logic [IDW-1:0] gnt_id,
  input logic           gnt_vld
);
  localparam logic [N-1:0] GNT_LSB = {{(N-1){1'b0}}, 1'b1};

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_vld     : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
  a_gnt_id      : assert property (@(posedge clk) disable iff (!rst_n)
                                   gnt_vld |-> (gnt == (GNT_LSB << gnt_id)));
endmodule

module rr_sel_arbiter #(
  parameter int N        = 3,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8
) (
  input logic             clk,
  input logic             rst_n,
  rr_sel_arbiter_if.slave bus
);
  localparam int             HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [N-1:0]   GNT_LSB   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] ID_LAST   = IDW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_vld_q, gnt_vld_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0] pick_s;
  logic           drop_s;
  logic           limit_s;

  // Scanning from the highest offset down lets the lowest offset from ptr win last.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0] w;
    logic [IDW-1:0] idx;
    w = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(p) + k) % N);
      w   = r[idx] ? idx : w;
    end
    return w;
  endfunction

  assign pick_s  = rr_pick(bus.req, ptr_q);
  assign drop_s  = ~bus.req[gnt_id_q];
  assign limit_s = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and next-output selection for the IDLE/GRANT controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d     = GNT_LSB << pick_s;
          gnt_id_d  = pick_s;
          gnt_vld_d = 1'b1;
          hold_d    = '0;
          state_d   = GRANT;
        end else begin
          state_d   = IDLE;
        end
      end
      GRANT: begin
        if (bus.rel || drop_s || limit_s) begin
          gnt_d     = '0;
          gnt_id_d  = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + IDW'(1);
          // A forced release is only reported when the owner did not let go itself.
          timeout_d = limit_s & ~bus.rel & ~drop_s;
          state_d   = IDLE;
        end else begin
          hold_d    = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        ptr_d     = '0;
        hold_d    = '0;
        gnt_d     = '0;
        gnt_id_d  = '0;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;

  rr_sel_arbiter_chk #(.N(N), .IDW(IDW)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt_q),
    .gnt_id  (gnt_id_q),
    .gnt_vld (gnt_vld_q)
  );
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-level ownership model.
module tb_rr_sel_arbiter;
  localparam int N        = 3;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;
  localparam int OW       = N + IDW + 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: who owns the bus, how many cycles it has owned it, where the scan starts.
  int   m_owner;
  int   m_hold;
  int   m_ptr;
  logic m_tmo;

  rr_sel_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  rr_sel_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OW-1:0] outs();
    return {bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout};
  endfunction

  // Expected {gnt, gnt_id, gnt_vld, timeout}; owner < 0 means nobody holds the bus.
  function automatic logic [OW-1:0] pack(input int owner, input logic tmo);
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           v;
    g = '0; id = '0; v = 1'b0;
    if (owner >= 0) begin
      g  = N'(1) << owner;
      id = IDW'(owner);
      v  = 1'b1;
    end
    return {g, id, v, tmo};
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_hold = 0; m_ptr = 0; m_tmo = 1'b0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic rl);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (r[IDW'((m_ptr + k) % N)]) begin
          m_owner = (m_ptr + k) % N;
          m_hold  = 1;
          break;
        end
      end
    end else if (rl || !r[IDW'(m_owner)] || (MAX_HOLD != 0 && m_hold == MAX_HOLD)) begin
      m_tmo   = !rl && r[IDW'(m_owner)];
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_hold++;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; bus.req = '0; bus.rel = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL reset_initial: got %b want %b", outs(), pack(-1, 1'b0)); end
    bus.req = 3'b111;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL reset_held: got %b want %b", outs(), pack(-1, 1'b0)); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (outs() !== pack(0, 1'b0)) begin n_err++; $display("FAIL reset_first_grant: got %b want %b", outs(), pack(0, 1'b0)); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL reset_async: got %b want %b", outs(), pack(-1, 1'b0)); end
  endtask

  task automatic test_single();
    bus.req = '0; bus.rel = 1'b0; rst_n = 1'b1;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL single_idle: got %b want %b", outs(), pack(-1, 1'b0)); end
    bus.req = 3'b010;
    tick();
    n_vec++; if (outs() !== pack(1, 1'b0)) begin n_err++; $display("FAIL single_grant: got %b want %b", outs(), pack(1, 1'b0)); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (outs() !== pack(1, 1'b0)) begin n_err++; $display("FAIL single_hold%0d: got %b want %b", i, outs(), pack(1, 1'b0)); end
    end
    bus.rel = 1'b1;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL single_release: got %b want %b", outs(), pack(-1, 1'b0)); end
    bus.rel = 1'b0; bus.req = 3'b111;
    tick();
    n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL single_ptr_next: got %b want %b", outs(), pack(2, 1'b0)); end
    bus.rel = 1'b1;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL single_release2: got %b want %b", outs(), pack(-1, 1'b0)); end
    bus.rel = 1'b0;
  endtask

  task automatic test_rotation();
    int order[5] = '{0, 1, 2, 0, 1};
    bus.req = 3'b111;
    for (int k = 0; k < 5; k++) begin
      bus.rel = 1'b0;
      tick();
      n_vec++; if (outs() !== pack(order[k], 1'b0)) begin n_err++; $display("FAIL rotation_grant%0d: got %b want %b", k, outs(), pack(order[k], 1'b0)); end
      bus.rel = 1'b1;
      tick();
      n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL rotation_bubble%0d: got %b want %b", k, outs(), pack(-1, 1'b0)); end
    end
    bus.rel = 1'b0; bus.req = '0;
    tick();
  endtask

  task automatic test_timeout();
    bus.req = 3'b100;
    tick();
    n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL timeout_grant: got %b want %b", outs(), pack(2, 1'b0)); end
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL timeout_hold%0d: got %b want %b", i, outs(), pack(2, 1'b0)); end
    end
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b1)) begin n_err++; $display("FAIL timeout_pulse: got %b want %b", outs(), pack(-1, 1'b1)); end
    tick();
    n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL timeout_regrant: got %b want %b", outs(), pack(2, 1'b0)); end
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL timeout_rehold%0d: got %b want %b", i, outs(), pack(2, 1'b0)); end
    end
    bus.rel = 1'b1;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL timeout_with_rel: got %b want %b", outs(), pack(-1, 1'b0)); end
    bus.rel = 1'b0; bus.req = '0;
    tick();
  endtask

  task automatic test_owner_drop();
    bus.req = 3'b011;
    tick();
    n_vec++; if (outs() !== pack(0, 1'b0)) begin n_err++; $display("FAIL drop_grant: got %b want %b", outs(), pack(0, 1'b0)); end
    bus.req = 3'b010;
    tick();
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL drop_release: got %b want %b", outs(), pack(-1, 1'b0)); end
    tick();
    n_vec++; if (outs() !== pack(1, 1'b0)) begin n_err++; $display("FAIL drop_next: got %b want %b", outs(), pack(1, 1'b0)); end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus.req = 3'b100;
    tick();
    n_vec++; if (outs() !== pack(2, 1'b0)) begin n_err++; $display("FAIL midrst_grant: got %b want %b", outs(), pack(2, 1'b0)); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL midrst_async: got %b want %b", outs(), pack(-1, 1'b0)); end
    tick();
    rst_n = 1'b1; bus.req = 3'b101;
    tick();
    n_vec++; if (outs() !== pack(0, 1'b0)) begin n_err++; $display("FAIL midrst_ptr0: got %b want %b", outs(), pack(0, 1'b0)); end
    bus.rel = 1'b1;
    tick();
    bus.rel = 1'b0; bus.req = '0;
  endtask

  task automatic test_random();
    rst_n = 1'b0; bus.req = '0; bus.rel = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
      bus.rel = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      model_step(bus.req, bus.rel);
      #1;
      n_vec++; if (outs() !== pack(m_owner, m_tmo)) begin n_err++; $display("FAIL random_c%0d: got %b want %b", c, outs(), pack(m_owner, m_tmo)); end
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (outs() !== pack(-1, 1'b0)) begin n_err++; $display("FAIL random_rst_c%0d: got %b want %b", c, outs(), pack(-1, 1'b0)); end
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    bus.req = '0; bus.rel = 1'b0; rst_n = 1'b1;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_owner_drop();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
